// File: rtl/accum_seq_core.sv
// Accumulator core: PC, IR, A/B registers, Z/C flags and a multi-cycle sequencer driving one sync RAM port.
// Optional MUL/DIV datapath enabled by defining ACCUM_SEQ_MULDIV_EN; default build decodes those opcodes as NOPs.
module accum_seq_core #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              zero_flag,
    output logic              carry_flag,
    output logic              halted
);

    localparam logic [3:0] OP_LDA  = 4'b1000;
    localparam logic [3:0] OP_LDB  = 4'b0100;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_ADDB = 4'b1011;
    localparam logic [3:0] OP_STA  = 4'b0110;
    localparam logic [3:0] OP_STB  = 4'b0111;
    localparam logic [3:0] OP_JMP  = 4'b1001;
    localparam logic [3:0] OP_JZ   = 4'b0011;
    localparam logic [3:0] OP_JC   = 4'b0101;
    localparam logic [3:0] OP_HLT  = 4'b1111;
`ifdef ACCUM_SEQ_MULDIV_EN
    localparam logic [3:0] OP_MUL  = 4'b1100;
    localparam logic [3:0] OP_DIV  = 4'b1010;
`endif

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   pc, pc_nxt;
    logic [3:0]          ir_op, ir_op_nxt;
    logic [ADDR_W-1:0]   ir_addr, ir_addr_nxt;
    logic [DATA_W-1:0]   a, a_nxt;
    logic [DATA_W-1:0]   b, b_nxt;
    logic                zf, zf_nxt;
    logic                cf, cf_nxt;

    logic [DATA_W:0]     sum_ab;
    logic [DATA_W:0]     sum_am;
    logic [DATA_W:0]     dif_am;

    // Top bit of the widened result is carry (add) or borrow (subtract).
    function automatic logic [DATA_W:0] add_c(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    function automatic logic [DATA_W:0] sub_b(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
        return {1'b0, x} - {1'b0, y};
    endfunction

    assign sum_ab = add_c(a, b);
    assign sum_am = add_c(a, mem_rdata);
    assign dif_am = sub_b(a, mem_rdata);

`ifdef ACCUM_SEQ_MULDIV_EN
    logic [2*DATA_W-1:0] prod_am;
    logic [DATA_W-1:0]   quot_am;
    logic [DATA_W-1:0]   rem_am;

    function automatic logic [2*DATA_W-1:0] mul_full(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
        return {{DATA_W{1'b0}}, x} * {{DATA_W{1'b0}}, y};
    endfunction

    // Division by zero yields all ones / original dividend instead of X.
    function automatic logic [DATA_W-1:0] div_q(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
        return (y == '0) ? '1 : x / y;
    endfunction

    function automatic logic [DATA_W-1:0] div_r(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
        return (y == '0) ? x : x % y;
    endfunction

    assign prod_am = mul_full(a, mem_rdata);
    assign quot_am = div_q(a, mem_rdata);
    assign rem_am  = div_r(a, mem_rdata);
`endif

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        ir_op_nxt   = ir_op;
        ir_addr_nxt = ir_addr;
        a_nxt       = a;
        b_nxt       = b;
        zf_nxt      = zf;
        cf_nxt      = cf;
        mem_addr    = pc;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        mem_wdata   = '0;

        case (state)
            S_FETCH: begin
                mem_rd    = 1'b1;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                ir_op_nxt   = mem_rdata[DATA_W-1 -: 4];
                ir_addr_nxt = mem_rdata[ADDR_W-1:0];
                pc_nxt      = pc + ADDR_W'(1);
                state_nxt   = S_EXEC;
            end
            S_EXEC: begin
                state_nxt = S_FETCH;
                case (ir_op)
                    OP_LDA, OP_LDB, OP_ADD, OP_SUB: begin
                        mem_addr  = ir_addr;
                        mem_rd    = 1'b1;
                        state_nxt = S_WB;
                    end
`ifdef ACCUM_SEQ_MULDIV_EN
                    OP_MUL, OP_DIV: begin
                        mem_addr  = ir_addr;
                        mem_rd    = 1'b1;
                        state_nxt = S_WB;
                    end
`endif
                    OP_STA: begin
                        mem_addr  = ir_addr;
                        mem_wr    = 1'b1;
                        mem_wdata = a;
                    end
                    OP_STB: begin
                        mem_addr  = ir_addr;
                        mem_wr    = 1'b1;
                        mem_wdata = b;
                    end
                    OP_JMP: pc_nxt = ir_addr;
                    OP_JZ:  if (zf) pc_nxt = ir_addr;
                    OP_JC:  if (cf) pc_nxt = ir_addr;
                    OP_ADDB: begin
                        a_nxt  = sum_ab[DATA_W-1:0];
                        cf_nxt = sum_ab[DATA_W];
                        zf_nxt = (sum_ab[DATA_W-1:0] == '0);
                    end
                    OP_HLT: state_nxt = S_HALT;
                    default: ;
                endcase
            end
            S_WB: begin
                state_nxt = S_FETCH;
                case (ir_op)
                    OP_LDA: begin
                        a_nxt  = mem_rdata;
                        zf_nxt = (mem_rdata == '0);
                    end
                    OP_LDB: b_nxt = mem_rdata;
                    OP_ADD: begin
                        a_nxt  = sum_am[DATA_W-1:0];
                        cf_nxt = sum_am[DATA_W];
                        zf_nxt = (sum_am[DATA_W-1:0] == '0);
                    end
                    OP_SUB: begin
                        a_nxt  = dif_am[DATA_W-1:0];
                        cf_nxt = dif_am[DATA_W];
                        zf_nxt = (dif_am[DATA_W-1:0] == '0);
                    end
`ifdef ACCUM_SEQ_MULDIV_EN
                    OP_MUL: begin
                        a_nxt  = prod_am[DATA_W-1:0];
                        b_nxt  = prod_am[2*DATA_W-1:DATA_W];
                        cf_nxt = |prod_am[2*DATA_W-1:DATA_W];
                        zf_nxt = (prod_am[DATA_W-1:0] == '0);
                    end
                    OP_DIV: begin
                        a_nxt  = quot_am;
                        b_nxt  = rem_am;
                        cf_nxt = (mem_rdata == '0);
                        zf_nxt = (quot_am == '0);
                    end
`endif
                    default: ;
                endcase
            end
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_FETCH;
        endcase

        // Reset wins over any in-flight strobe so the RAM never sees a read or write in the reset cycle.
        if (reset) begin
            mem_rd = 1'b0;
            mem_wr = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_FETCH;
            pc      <= ADDR_W'(RESET_PC);
            ir_op   <= '0;
            ir_addr <= '0;
            a       <= '0;
            b       <= '0;
            zf      <= 1'b0;
            cf      <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            ir_op   <= ir_op_nxt;
            ir_addr <= ir_addr_nxt;
            a       <= a_nxt;
            b       <= b_nxt;
            zf      <= zf_nxt;
            cf      <= cf_nxt;
        end
    end

    assign a_out      = a;
    assign b_out      = b;
    assign pc_out     = pc;
    assign zero_flag  = zf;
    assign carry_flag = cf;
    assign halted     = (state == S_HALT);

endmodule

// File: tb/tb_accum_seq_core.sv
// Bench for accum_seq_core: directed scenarios plus random programs checked against an instruction-level model.
// Builds with or without ACCUM_SEQ_MULDIV_EN; expectations follow the macro.
module tb_accum_seq_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [3:0] mem_addr;
    logic       mem_rd;
    logic [7:0] mem_rdata;
    logic       mem_wr;
    logic [7:0] mem_wdata;
    logic [7:0] a_out;
    logic [7:0] b_out;
    logic [3:0] pc_out;
    logic       zero_flag;
    logic       carry_flag;
    logic       halted;

    logic [3:0] mem_addr_w;
    logic       mem_rd_w;
    logic       mem_wr_w;
    logic [7:0] mem_wdata_w;
    logic [7:0] a_w;
    logic [7:0] b_w;
    logic [3:0] pc_w;
    logic       zero_w;
    logic       carry_w;
    logic       halted_w;

    accum_seq_core #(.DATA_W(8), .ADDR_W(4), .RESET_PC(0)) dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .mem_wr(mem_wr), .mem_wdata(mem_wdata), .a_out(a_out), .b_out(b_out), .pc_out(pc_out),
        .zero_flag(zero_flag), .carry_flag(carry_flag), .halted(halted)
    );

    // Second core starting at the top of the address space; its memory is all zeros (NOPs).
    accum_seq_core #(.DATA_W(8), .ADDR_W(4), .RESET_PC(15)) dut_w (
        .clk(clk), .reset(reset), .mem_addr(mem_addr_w), .mem_rd(mem_rd_w), .mem_rdata(8'h00),
        .mem_wr(mem_wr_w), .mem_wdata(mem_wdata_w), .a_out(a_w), .b_out(b_w), .pc_out(pc_w),
        .zero_flag(zero_w), .carry_flag(carry_w), .halted(halted_w)
    );

`ifdef ACCUM_SEQ_MULDIV_EN
    localparam bit MULDIV = 1'b1;
`else
    localparam bit MULDIV = 1'b0;
`endif

    logic [7:0] ram [16];
    logic [7:0] img [16];
    logic       load;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 16; i++) ram[i] <= img[i];
        end else if (mem_wr) begin
            ram[mem_addr] <= mem_wdata;
        end
        if (mem_rd) mem_rdata <= ram[mem_addr];
    end

    int total = 0;
    int bad   = 0;

    int m_pc, m_a, m_b;
    bit m_z, m_c, m_halt;
    int mm [16];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_img;
        for (int i = 0; i < 16; i++) img[i] = 8'h00;
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        load  = 1'b1;
        tick(2);
        load  = 1'b0;
    endtask

    // Instruction-level reference: one call executes one whole instruction and reports its cycle cost.
    task automatic model_step(output int cost);
        int w, op, ad, m, s, p;
        w    = mm[m_pc];
        m_pc = (m_pc + 1) % 16;
        op   = w / 16;
        ad   = w % 16;
        m    = mm[ad];
        cost = 3;
        case (op)
            8:  begin m_a = m; m_z = (m_a == 0); cost = 4; end
            4:  begin m_b = m; cost = 4; end
            2:  begin s = m_a + m; m_c = (s > 255); m_a = s % 256; m_z = (m_a == 0); cost = 4; end
            1:  begin m_c = (m_a < m); m_a = (m_a - m + 256) % 256; m_z = (m_a == 0); cost = 4; end
            11: begin s = m_a + m_b; m_c = (s > 255); m_a = s % 256; m_z = (m_a == 0); end
            6:  mm[ad] = m_a;
            7:  mm[ad] = m_b;
            9:  m_pc = ad;
            3:  if (m_z) m_pc = ad;
            5:  if (m_c) m_pc = ad;
            15: m_halt = 1'b1;
            12: if (MULDIV) begin
                    p = m_a * m; m_b = p / 256; m_a = p % 256;
                    m_c = (m_b != 0); m_z = (m_a == 0); cost = 4;
                end
            10: if (MULDIV) begin
                    if (m == 0) begin m_b = m_a; m_a = 255; m_c = 1'b1; m_z = 1'b0; end
                    else begin m_b = m_a % m; m_a = m_a / m; m_c = 1'b0; m_z = (m_a == 0); end
                    cost = 4;
                end
            default: ;
        endcase
    endtask

    task automatic test_reset;
        clear_img();
        apply_reset();
        total++; if (mem_rd !== 1'b0) begin bad++; $display("FAIL rst mem_rd: got %0b want 0", mem_rd); end
        total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL rst mem_wr: got %0b want 0", mem_wr); end
        total++; if (pc_out !== 4'h0) begin bad++; $display("FAIL rst pc: got %0h want 0", pc_out); end
        total++; if (a_out !== 8'h00 || b_out !== 8'h00) begin bad++; $display("FAIL rst ab: got %0h/%0h want 0/0", a_out, b_out); end
        total++; if (zero_flag !== 1'b0 || carry_flag !== 1'b0) begin bad++; $display("FAIL rst flags: got z%0b c%0b want z0 c0", zero_flag, carry_flag); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst halted: got %0b want 0", halted); end
    endtask

    task automatic test_basic;
        int cycles;
        clear_img();
        img[0] = 8'h8E; img[1] = 8'h2F; img[2] = 8'h6D; img[3] = 8'hF0;
        img[14] = 8'h05; img[15] = 8'h07;
        apply_reset();
        reset = 1'b0;
        cycles = 0;
        while (halted !== 1'b1 && cycles < 100) begin
            tick(1);
            cycles++;
        end
        total++; if (cycles != 14) begin bad++; $display("FAIL basic cycles: got %0d want 14", cycles); end
        total++; if (a_out !== 8'h0C) begin bad++; $display("FAIL basic a: got %0h want 0c", a_out); end
        total++; if (ram[13] !== 8'h0C) begin bad++; $display("FAIL basic mem13: got %0h want 0c", ram[13]); end
        total++; if (zero_flag !== 1'b0 || carry_flag !== 1'b0) begin bad++; $display("FAIL basic flags: got z%0b c%0b want z0 c0", zero_flag, carry_flag); end
        total++; if (pc_out !== 4'h4) begin bad++; $display("FAIL basic pc: got %0h want 4", pc_out); end
        tick(3);
        total++; if (halted !== 1'b1 || mem_rd !== 1'b0 || mem_wr !== 1'b0 || pc_out !== 4'h4)
            begin bad++; $display("FAIL halt hold: got h%0b rd%0b wr%0b pc%0h want h1 rd0 wr0 pc4", halted, mem_rd, mem_wr, pc_out); end
    endtask

    task automatic test_carry;
        clear_img();
        img[0] = 8'h8E; img[1] = 8'h2F; img[2] = 8'h1F; img[3] = 8'hF0;
        img[14] = 8'hFF; img[15] = 8'h01;
        apply_reset();
        reset = 1'b0;
        tick(8);
        total++; if (a_out !== 8'h00 || zero_flag !== 1'b1 || carry_flag !== 1'b1)
            begin bad++; $display("FAIL add wrap: got a%0h z%0b c%0b want a0 z1 c1", a_out, zero_flag, carry_flag); end
        tick(4);
        total++; if (a_out !== 8'hFF || zero_flag !== 1'b0 || carry_flag !== 1'b1)
            begin bad++; $display("FAIL sub borrow: got a%0h z%0b c%0b want aff z0 c1", a_out, zero_flag, carry_flag); end
    endtask

    task automatic test_jumps;
        // JZ taken / not taken
        for (int k = 0; k < 2; k++) begin
            clear_img();
            img[0] = 8'h8E; img[1] = 8'h38; img[2] = 8'hF0; img[8] = 8'hF0;
            img[14] = (k == 0) ? 8'h00 : 8'h05;
            apply_reset();
            reset = 1'b0;
            tick(7);
            total++; if (pc_out !== ((k == 0) ? 4'h8 : 4'h2))
                begin bad++; $display("FAIL jz case%0d pc: got %0h want %0h", k, pc_out, (k == 0) ? 4'h8 : 4'h2); end
        end
        // JC taken / not taken
        for (int k = 0; k < 2; k++) begin
            clear_img();
            img[0] = 8'h8E; img[1] = 8'h2F; img[2] = 8'h58; img[3] = 8'hF0; img[8] = 8'hF0;
            img[14] = 8'hFF; img[15] = (k == 0) ? 8'h01 : 8'h00;
            apply_reset();
            reset = 1'b0;
            tick(11);
            total++; if (pc_out !== ((k == 0) ? 4'h8 : 4'h3))
                begin bad++; $display("FAIL jc case%0d pc: got %0h want %0h", k, pc_out, (k == 0) ? 4'h8 : 4'h3); end
        end
        // Jump to self loops forever
        clear_img();
        img[0] = 8'h90;
        apply_reset();
        reset = 1'b0;
        tick(33);
        total++; if (pc_out !== 4'h0 || halted !== 1'b0)
            begin bad++; $display("FAIL self jmp: got pc%0h h%0b want pc0 h0", pc_out, halted); end
    endtask

    task automatic test_pc_wrap;
        apply_reset();
        total++; if (pc_w !== 4'hF) begin bad++; $display("FAIL wrap rst pc: got %0h want f", pc_w); end
        reset = 1'b0;
        tick(2);
        total++; if (pc_w !== 4'h0) begin bad++; $display("FAIL wrap pc: got %0h want 0", pc_w); end
        total++; if (mem_rd_w !== 1'b0 || mem_wr_w !== 1'b0)
            begin bad++; $display("FAIL wrap nop strobes: got rd%0b wr%0b want rd0 wr0", mem_rd_w, mem_wr_w); end
        tick(3);
        total++; if (pc_w !== 4'h1) begin bad++; $display("FAIL wrap next pc: got %0h want 1", pc_w); end
        total++; if (a_w !== 8'h00 || b_w !== 8'h00 || zero_w !== 1'b0 || carry_w !== 1'b0 || halted_w !== 1'b0)
            begin bad++; $display("FAIL wrap regs: got a%0h b%0h z%0b c%0b h%0b want all 0", a_w, b_w, zero_w, carry_w, halted_w); end
        $display("note: wrap core addr=%0h wdata=%0h", mem_addr_w, mem_wdata_w);
    endtask

    task automatic test_reset_mid;
        clear_img();
        img[0] = 8'h8E; img[1] = 8'h6D; img[2] = 8'hF0; img[14] = 8'h5A;
        apply_reset();
        reset = 1'b0;
        tick(3);
        reset = 1'b1;
        #1;
        total++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0)
            begin bad++; $display("FAIL midrst strobes: got rd%0b wr%0b want 0 0", mem_rd, mem_wr); end
        tick(1);
        total++; if (a_out !== 8'h00 || pc_out !== 4'h0)
            begin bad++; $display("FAIL midrst regs: got a%0h pc%0h want a0 pc0", a_out, pc_out); end
        reset = 1'b0;
        #1;
        total++; if (mem_rd !== 1'b1 || mem_addr !== 4'h0)
            begin bad++; $display("FAIL midrst resume: got rd%0b addr%0h want rd1 addr0", mem_rd, mem_addr); end
        tick(4);
        total++; if (a_out !== 8'h5A) begin bad++; $display("FAIL midrst lda: got %0h want 5a", a_out); end
        // Reset landing on the EXEC of STA must suppress the write.
        tick(2);
        total++; if (mem_wr !== 1'b1 || mem_addr !== 4'hD)
            begin bad++; $display("FAIL sta exec: got wr%0b addr%0h want wr1 addrd", mem_wr, mem_addr); end
        reset = 1'b1;
        #1;
        total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL sta rst wr: got %0b want 0", mem_wr); end
        tick(1);
        total++; if (ram[13] !== 8'h00) begin bad++; $display("FAIL sta rst mem13: got %0h want 00", ram[13]); end
    endtask

    task automatic test_muldiv;
        clear_img();
        img[0] = 8'h8E; img[1] = 8'hCF; img[2] = 8'hF0; img[14] = 8'h20; img[15] = 8'h10;
        apply_reset();
        reset = 1'b0;
`ifdef ACCUM_SEQ_MULDIV_EN
        tick(8);
        total++; if (a_out !== 8'h00 || b_out !== 8'h02 || zero_flag !== 1'b1 || carry_flag !== 1'b1)
            begin bad++; $display("FAIL mul: got a%0h b%0h z%0b c%0b want a0 b2 z1 c1", a_out, b_out, zero_flag, carry_flag); end
`else
        tick(7);
        total++; if (a_out !== 8'h20 || b_out !== 8'h00 || pc_out !== 4'h2)
            begin bad++; $display("FAIL mul nop: got a%0h b%0h pc%0h want a20 b0 pc2", a_out, b_out, pc_out); end
        tick(3);
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL mul nop halt: got %0b want 1", halted); end
`endif
        clear_img();
        img[0] = 8'h8E; img[1] = 8'hAF; img[2] = 8'hF0; img[14] = 8'h07; img[15] = 8'h00;
        apply_reset();
        reset = 1'b0;
`ifdef ACCUM_SEQ_MULDIV_EN
        tick(8);
        total++; if (a_out !== 8'hFF || b_out !== 8'h07 || carry_flag !== 1'b1 || zero_flag !== 1'b0)
            begin bad++; $display("FAIL div0: got a%0h b%0h c%0b z%0b want aff b7 c1 z0", a_out, b_out, carry_flag, zero_flag); end
`else
        tick(7);
        total++; if (a_out !== 8'h07 || b_out !== 8'h00 || carry_flag !== 1'b0 || pc_out !== 4'h2)
            begin bad++; $display("FAIL div nop: got a%0h b%0h c%0b pc%0h want a7 b0 c0 pc2", a_out, b_out, carry_flag, pc_out); end
`endif
    endtask

    task automatic test_random;
        int cost;
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 16; i++) begin
                img[i] = 8'($urandom_range(0, 255));
                mm[i]  = int'(img[i]);
            end
            m_pc = 0; m_a = 0; m_b = 0; m_z = 1'b0; m_c = 1'b0; m_halt = 1'b0;
            apply_reset();
            reset = 1'b0;
            for (int s = 0; s < 40; s++) begin
                total++;
                if (pc_out !== 4'(m_pc) || a_out !== 8'(m_a) || b_out !== 8'(m_b) ||
                    zero_flag !== m_z || carry_flag !== m_c || halted !== m_halt) begin
                    bad++;
                    $display("FAIL rand p%0d s%0d: got pc%0h a%0h b%0h z%0b c%0b h%0b want pc%0h a%0h b%0h z%0b c%0b h%0b",
                             t, s, pc_out, a_out, b_out, zero_flag, carry_flag, halted,
                             m_pc, m_a, m_b, m_z, m_c, m_halt);
                end
                if (m_halt) break;
                model_step(cost);
                for (int c = 0; c < cost; c++) begin
                    tick(1);
                    total++;
                    if (mem_rd === 1'b1 && mem_wr === 1'b1) begin
                        bad++; $display("FAIL rand strobes p%0d: got rd1 wr1 want not both", t);
                    end
                end
            end
            for (int i = 0; i < 16; i++) begin
                total++;
                if (ram[i] !== 8'(mm[i])) begin
                    bad++; $display("FAIL rand mem p%0d[%0d]: got %0h want %0h", t, i, ram[i], mm[i]);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        load  = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_jumps();
        test_pc_wrap();
        test_reset_mid();
        test_muldiv();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/accum_seq_core.md
Name: accum_seq_core

Overview:
- Parametrised successor to the 4-bit fetch/decode controller. Combines program counter, instruction register, A/B registers, flags and a multi-cycle sequencer in one block.
- Drives a single external synchronous RAM port (1-cycle read latency) that holds both program and data.
- Width, address space and instruction set are generalised: adds stores, conditional jumps and flags.

Parameters:
- DATA_W, 8, memory word / register width; must satisfy DATA_W >= 4 + ADDR_W.
- ADDR_W, 4, address width; PC and operand address width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  synchronous, active-high.
- mem_addr  output  ADDR_W  RAM address.
- mem_rd  output  1  read strobe; mem_rdata valid the following cycle.
- mem_rdata  input  DATA_W  RAM read data.
- mem_wr  output  1  write strobe; RAM writes mem_wdata at mem_addr on this edge.
- mem_wdata  output  DATA_W  RAM write data.
- a_out  output  DATA_W  register A.
- b_out  output  DATA_W  register B.
- pc_out  output  ADDR_W  program counter.
- zero_flag  output  1  Z flag.
- carry_flag  output  1  C flag.
- halted  output  1  core in HALT state.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: pc=RESET_PC; A, B, IR = 0; Z = C = 0; state = FETCH; halted = 0. mem_rd = mem_wr = 0 during the reset cycle.
- Instruction format: opcode = mem_rdata[DATA_W-1:DATA_W-4]; operand address = mem_rdata[ADDR_W-1:0]. Bits in between are ignored.
- Opcodes:
  - LDA 1000: A <= M.
  - LDB 0100: B <= M.
  - ADD 0010: A <= A + M.
  - SUB 0001: A <= A - M.
  - ADDB 1011: A <= A + B.
  - STA 0110: M <= A.
  - STB 0111: M <= B.
  - JMP 1001: pc <= addr.
  - JZ 0011: jump if Z.
  - JC 0101: jump if C.
  - HLT 1111.
  - MUL 1100 / DIV 1010: see Optional Feature.
  - All other codes: NOP.
- State machine:
  - FETCH: mem_addr = pc, mem_rd = 1 -> DECODE.
  - DECODE: IR <= mem_rdata; pc <= pc + 1 (wraps 2^ADDR_W-1 -> 0) -> EXEC.
  - EXEC, memory-read ops (LDA, LDB, ADD, SUB, MUL, DIV): mem_addr = IR.addr, mem_rd = 1 -> WB.
  - EXEC, STA/STB: mem_wr = 1, mem_addr = IR.addr, mem_wdata = A or B -> FETCH.
  - EXEC, jumps: pc <= addr if the condition is true, else pc unchanged -> FETCH.
  - EXEC, ADDB: update A and flags -> FETCH.
  - EXEC, NOP: -> FETCH.
  - EXEC, HLT: -> HALT.
  - WB: update registers and flags from mem_rdata -> FETCH.
  - HALT: absorbing; all strobes 0; halted = 1; left only by reset.
- Instruction cost: memory-read ops 4 cycles; all others 3 cycles.
- Arithmetic and flags:
  - All arithmetic is modulo 2^DATA_W.
  - ADD/ADDB: C = carry out.
  - SUB: C = borrow (1 when A < M).
  - Z = (new A == 0), updated by LDA, ADD, ADDB, SUB, MUL, DIV.
  - LDB, stores and jumps leave flags unchanged.
- Strobes: mem_rd and mem_wr are never asserted together; both are 0 outside FETCH/EXEC.
- Reset asserted in any state, including mid-EXEC or WB, takes effect on that edge. A pending read result is discarded and no write occurs in the reset cycle.
- A jump to the instruction's own address is legal and loops indefinitely.

Optional Feature:
- Macro: ACCUM_SEQ_MULDIV_EN.
- With the macro defined:
  - MUL: {B, A} <= A * M (full 2*DATA_W product; B holds the high half).
  - DIV: A <= A / M, B <= A % M.
  - Divide by zero: A <= all ones, B <= original A, C <= 1.
  - Both are 4-cycle memory-read ops.
  - Otherwise C <= 0 for both; for MUL, C <= 1 when the high half is nonzero.
- Without the macro: 1100 and 1010 decode as 3-cycle NOPs; no multiplier/divider logic is synthesised.

Test Plan:
- Basic load/add/store (DATA_W=8, ADDR_W=4). RAM: [0]=0x8E, [1]=0x2F, [2]=0x6D, [3]=0xF0, [14]=0x05, [15]=0x07; release reset -> A=0x0C, mem[13]=0x0C, Z=0, C=0, halted=1 exactly 14 cycles after reset deassert, pc_out=4.
- Carry and wrap: A=0xFF via LDA, ADD of 0x01 -> A=0x00, Z=1, C=1. SUB 0x01 -> A=0xFF, C=1 (borrow), Z=0.
- Conditional jumps: after Z=1, JZ to 0x8 -> pc_out=8 on the next FETCH. With Z=0 the same JZ -> pc_out equals the jump's address+1. Check JC likewise.
- PC wrap: [15]=0x00 (NOP) and RESET_PC=15 -> after the first DECODE pc_out=0.
- Reset mid-operation: assert reset during WB of LDA 0x5A -> A stays 0x00, pc_out=RESET_PC, mem_rd=mem_wr=0 in the reset cycle; normal fetch resumes the cycle after release.
- Multiply/divide (with ACCUM_SEQ_MULDIV_EN): A=0x20, MUL 0x10 -> A=0x00, B=0x02, Z=1, C=1. A=0x07, DIV 0x00 -> A=0xFF, B=0x07, C=1. Without the macro, same program: A and B unchanged and each op takes 3 cycles.
